// File: rtl/ln_series_pkg.sv
// Shared types and constants for the ln(1+x) series engine.
package ln_series_pkg;

   localparam int unsigned DATA_W     = 17;
   localparam int unsigned N_W        = 4;
   localparam int unsigned RECIP_W    = 8;
   localparam int unsigned FRAC_BITS  = 14;
   localparam int unsigned RECIP_FRAC = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MUL  = 3'd2,
      ADD  = 3'd3,
      DONE = 3'd4
   } state_t;

   // round(256/n) in Q0.8; entries 0 and 1 are never used by the series
   localparam logic [RECIP_W-1:0] RECIP_TABLE [16] = '{
      8'd0,   8'd0,   8'd128, 8'd85,  8'd64,  8'd51,  8'd43, 8'd37,
      8'd32,  8'd28,  8'd26,  8'd23,  8'd21,  8'd20,  8'd18, 8'd17
   };

endpackage

// File: rtl/ln_recip_rom.sv
// Combinational reciprocal lookup: n -> round(256/n), unsigned Q0.8.
module ln_recip_rom
   import ln_series_pkg::*;
(
   input  logic [N_W-1:0]     i_addr,
   output logic [RECIP_W-1:0] o_data
);

   assign o_data = RECIP_TABLE[i_addr];

endmodule

// File: rtl/ln_series.sv
// Iterative Taylor series for ln(1+x) in Q2.14, one term per MUL/ADD pair.
// Optional operand range check enabled by defining LN_RANGE_CHECK_EN.
module ln_series
   import ln_series_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] x,
   input  logic [N_W-1:0]           n_terms,
   output logic                     busy,
   output logic                     done,
   output logic signed [DATA_W-1:0] result,
   output logic                     err
);

   state_t                     r_state;
   logic signed [DATA_W-1:0]   r_x;
   logic signed [DATA_W-1:0]   r_pow;
   logic signed [DATA_W-1:0]   r_term;
   logic signed [DATA_W-1:0]   r_acc;
   logic [N_W-1:0]             r_n;
   logic [N_W-1:0]             r_n_max;
   logic                       r_oor;

   logic [RECIP_W-1:0]         w_recip;
   logic signed [25:0]         w_term_prod;
   logic signed [33:0]         w_pow_prod;
   logic signed [DATA_W-1:0]   w_term;
   logic signed [DATA_W-1:0]   w_pow_next;
   logic                       w_oor;

   ln_recip_rom u_recip (
      .i_addr (r_n),
      .o_data (w_recip)
   );

   // Term n scales x^n by 1/n; the Q0.8 reciprocal is dropped after the product.
   assign w_term_prod = 26'(r_pow) * 26'($signed({1'b0, w_recip}));
   assign w_pow_prod  = 34'(r_pow) * 34'(r_x);
   assign w_term      = (r_n == N_W'(1)) ? r_pow : w_term_prod[RECIP_FRAC +: DATA_W];
   assign w_pow_next  = w_pow_prod[FRAC_BITS +: DATA_W];

`ifdef LN_RANGE_CHECK_EN
   assign w_oor = (x >= 17'sd16384) || (x <= -17'sd16384);
`else
   assign w_oor = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_pow   <= '0;
         r_term  <= '0;
         r_acc   <= '0;
         r_n     <= '0;
         r_n_max <= '0;
         r_oor   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         err     <= 1'b0;
      end else begin
         busy <= (r_state == LOAD) || (r_state == MUL) || (r_state == ADD);
         done <= (r_state == DONE);
         case (r_state)
            IDLE: begin
               if (start) r_state <= LOAD;
            end
            LOAD: begin
               r_x     <= x;
               r_pow   <= x;
               r_n_max <= n_terms;
               r_acc   <= '0;
               r_n     <= N_W'(1);
               r_oor   <= w_oor;
               r_state <= ((n_terms == '0) || w_oor) ? DONE : MUL;
            end
            MUL: begin
               r_term  <= w_term;
               r_pow   <= w_pow_next;
               r_state <= ADD;
            end
            ADD: begin
               r_acc   <= r_n[0] ? (r_acc + r_term) : (r_acc - r_term);
               r_n     <= r_n + N_W'(1);
               r_state <= (r_n < r_n_max) ? MUL : DONE;
            end
            DONE: begin
               result  <= r_oor ? '0 : r_acc;
               err     <= r_oor;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ln_series.sv
// Randomized self-checking bench for ln_series against an arithmetic series model.
module tb_ln_series;

   logic               clk;
   logic               rst;
   logic               start;
   logic signed [16:0] x;
   logic [3:0]         n_terms;
   logic               busy;
   logic               done;
   logic signed [16:0] result;
   logic               err;

   int n_checks = 0;
   int n_errors = 0;

   ln_series dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .x       (x),
      .n_terms (n_terms),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrap17(input longint v);
      longint t;
      t = v & 64'h1FFFF;
      if (t >= 65536) t = t - 131072;
      return t;
   endfunction

   // ln(1+x) ~ sum (-1)^(k+1) x^k / k with the fixed-point truncations applied
   function automatic longint model(input longint xv, input int nn);
      longint p, acc, term, r;
      p   = xv;
      acc = 0;
      for (int k = 1; k <= nn; k++) begin
         r    = (256 + k / 2) / k;
         term = (k == 1) ? p : wrap17((p * r) >>> 8);
         acc  = wrap17((k % 2 == 1) ? acc + term : acc - term);
         p    = wrap17((p * xv) >>> 14);
      end
      return acc;
   endfunction

   function automatic bit out_of_range(input logic signed [16:0] xv);
`ifdef LN_RANGE_CHECK_EN
      return (xv >= 17'sd16384) || (xv <= -17'sd16384);
`else
      return (xv == 17'sd0) && (xv != 17'sd0);
`endif
   endfunction

   task automatic run_op(input logic signed [16:0] xv, input logic [3:0] nv, input bit mid_pulse);
      int lat, busy_cnt, exp_lat, exp_busy, exp_res, exp_err;
      bit seen;
      exp_err  = out_of_range(xv) ? 1 : 0;
      exp_lat  = exp_err ? 2 : 2 + 2 * int'(nv);
      exp_busy = exp_err ? 1 : 1 + 2 * int'(nv);
      exp_res  = exp_err ? 0 : int'(model(longint'(xv), int'(nv)));
      @(negedge clk);
      start = 1'b1; x = xv; n_terms = nv;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            x       = 17'($urandom);
            n_terms = 4'($urandom);
            if (mid_pulse) start = 1'b1;
         end
         if (lat == 2) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
      end
      chk("latency", lat, exp_lat);
      chk("busy_cycles", busy_cnt, exp_busy);
      chk("result", int'(result), exp_res);
      chk("err", int'(err), exp_err);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("done_pulse", int'(done), 0);
      end
      chk("result_hold", int'(result), exp_res);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; x = '0; n_terms = '0;
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_err", int'(err), 0);
      @(negedge clk); rst = 1'b1;

      run_op(17'sd8192, 4'd1, 1'b0);
      run_op(17'sd8192, 4'd2, 1'b0);
      run_op(-17'sd8192, 4'd2, 1'b0);
      run_op(17'sd8192, 4'd0, 1'b0);
      run_op(17'sd8192, 4'd3, 1'b1);
      run_op(17'sd16384, 4'd3, 1'b0);
      run_op(-17'sd16384, 4'd5, 1'b0);
      run_op(17'sd16383, 4'd15, 1'b0);
      run_op(-17'sd16383, 4'd15, 1'b1);

      for (int i = 0; i < 24; i++) begin
         logic signed [16:0] xv;
         logic [3:0] nv;
         if (i % 4 == 0) xv = 17'($urandom);
         else            xv = 17'(int'($urandom_range(0, 32766)) - 16383);
         nv = 4'($urandom_range(0, 15));
         run_op(xv, nv, (nv != 4'd0) && ($urandom_range(0, 1) == 1));
      end

      // Reset during an ADD cycle of an 8-term run
      run_op(17'sd12000, 4'd4, 1'b0);
      @(negedge clk);
      start = 1'b1; x = 17'sd8192; n_terms = 4'd8;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_result", int'(result), 0);
      chk("midrst_err", int'(err), 0);
      @(negedge clk); rst = 1'b1;
      run_op(17'sd8192, 4'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
